fetch_decode_ctrl: RTL and testbench

- Sequencing controller for the fetch-to-decode pipeline latch.
- Generates that latch's stall and flush controls, plus the fetch-stage stall.
- Arbitrates between two redirect sources (exception and branch mispredict) and issues a single registered redirect to fetch.
- Watches refill after a redirect with a timeout/retry counter, and keeps saturating stall and flush statistics counters.

---
 rtl/fetch_decode_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_decode_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_ctrl.sv
// rtl/fetch_decode_ctrl.sv - fetch-to-decode latch sequencing, redirect arbitration and refill watchdog
module fetch_decode_ctrl #(
    parameter int SIZE_PC        = 32,
    parameter int REFILL_TIMEOUT = 16,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exceptionFlush_i,
    input  logic [SIZE_PC-1:0] exceptionPC_i,
    input  logic               mispredFlush_i,
    input  logic [SIZE_PC-1:0] mispredPC_i,
    input  logic               decodeStall_i,
    input  logic               fs2Ready_i,
    output logic               f2dStall_o,
    output logic               f2dFlush_o,
    output logic               fetchStall_o,
    output logic               redirectEn_o,
    output logic [SIZE_PC-1:0] redirectPC_o,
    output logic [1:0]         ctrlState_o,
    output logic [CNT_W-1:0]   stallCount_o,
    output logic [CNT_W-1:0]   flushCount_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        REFILL = 2'd3
    } state_t;

    // Refill counter only has to reach REFILL_TIMEOUT-1.
    localparam int RC_W = (REFILL_TIMEOUT > 2) ? $clog2(REFILL_TIMEOUT) : 1;
    // Timeout fires in the cycle the counter would step onto REFILL_TIMEOUT-1,
    // so the retry FLUSH lands exactly REFILL_TIMEOUT cycles after the previous one.
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFILL_TIMEOUT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state;
    logic [SIZE_PC-1:0] pend_pc;
    logic [RC_W-1:0]    refill_cnt;

    logic               flush_req;
    logic [SIZE_PC-1:0] flush_pc;
    logic               refill_timeout;
    logic               go_flush;
    logic [SIZE_PC-1:0] pend_next;
    logic               stall_live;
    logic               stall_next;

    // Redirect arbitration: exception beats mispredict; timeout retry reuses pendPC.
    always_comb begin
        flush_req      = exceptionFlush_i | mispredFlush_i;
        flush_pc       = exceptionFlush_i ? exceptionPC_i : mispredPC_i;
        refill_timeout = (state == REFILL) && !fs2Ready_i && (refill_cnt == RC_LAST);
        go_flush       = flush_req | refill_timeout;
        pend_next      = flush_req ? flush_pc : pend_pc;
        stall_live     = reset && (state != FLUSH) && decodeStall_i;
        stall_next     = decodeStall_i;
    end

    assign f2dStall_o   = stall_live;
    assign fetchStall_o = stall_live;
    assign ctrlState_o  = state;

    // Main controller: state, pending PC, registered redirect outputs and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            pend_pc      <= '0;
            refill_cnt   <= '0;
            f2dFlush_o   <= 1'b0;
            redirectEn_o <= 1'b0;
            redirectPC_o <= '0;
            stallCount_o <= '0;
            flushCount_o <= '0;
        end else begin
            f2dFlush_o   <= 1'b0;
            redirectEn_o <= 1'b0;
            if (go_flush) begin
                state        <= FLUSH;
                pend_pc      <= pend_next;
                redirectPC_o <= pend_next;
                f2dFlush_o   <= 1'b1;
                redirectEn_o <= 1'b1;
                if (flushCount_o != '1) begin
                    flushCount_o <= flushCount_o + CNT_ONE;
                end
            end else begin
                case (state)
                    RUN, STALL: begin
                        state <= stall_next ? STALL : RUN;
                    end
                    FLUSH: begin
                        state      <= REFILL;
                        refill_cnt <= '0;
                    end
                    REFILL: begin
                        if (fs2Ready_i) begin
                            state <= stall_next ? STALL : RUN;
                        end else begin
                            refill_cnt <= refill_cnt + RC_W'(1);
                        end
                    end
                    default: state <= RUN;
                endcase
            end
            if (stall_live && (stallCount_o != '1)) begin
                stallCount_o <= stallCount_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb/tb_fetch_decode_ctrl.sv - directed vector bench for fetch_decode_ctrl
module tb_fetch_decode_ctrl;

    localparam int SIZE_PC = 32;
    localparam int TMO     = 16;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               exceptionFlush_i;
    logic [SIZE_PC-1:0] exceptionPC_i;
    logic               mispredFlush_i;
    logic [SIZE_PC-1:0] mispredPC_i;
    logic               decodeStall_i;
    logic               fs2Ready_i;
    logic               f2dStall_o;
    logic               f2dFlush_o;
    logic               fetchStall_o;
    logic               redirectEn_o;
    logic [SIZE_PC-1:0] redirectPC_o;
    logic [1:0]         ctrlState_o;
    logic [CNT_W-1:0]   stallCount_o;
    logic [CNT_W-1:0]   flushCount_o;

    int checks = 0;
    int failures = 0;

    fetch_decode_ctrl #(.SIZE_PC(SIZE_PC), .REFILL_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .exceptionFlush_i (exceptionFlush_i),
        .exceptionPC_i    (exceptionPC_i),
        .mispredFlush_i   (mispredFlush_i),
        .mispredPC_i      (mispredPC_i),
        .decodeStall_i    (decodeStall_i),
        .fs2Ready_i       (fs2Ready_i),
        .f2dStall_o       (f2dStall_o),
        .f2dFlush_o       (f2dFlush_o),
        .fetchStall_o     (fetchStall_o),
        .redirectEn_o     (redirectEn_o),
        .redirectPC_o     (redirectPC_o),
        .ctrlState_o      (ctrlState_o),
        .stallCount_o     (stallCount_o),
        .flushCount_o     (flushCount_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc;
        logic [31:0] epc;
        logic        mis;
        logic [31:0] mpc;
        logic        ds;
        logic        rdy;
        logic        e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
        logic [7:0]  e_sc;
        logic [7:0]  e_fc;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic exc, logic [31:0] epc, logic mis, logic [31:0] mpc,
                                logic ds, logic rdy, logic e_stall, logic e_flush,
                                logic [31:0] e_pc, logic [1:0] e_st, logic [7:0] e_sc,
                                logic [7:0] e_fc);
        vec_t v;
        v.exc = exc; v.epc = epc; v.mis = mis; v.mpc = mpc; v.ds = ds; v.rdy = rdy;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc; v.e_st = e_st;
        v.e_sc = e_sc; v.e_fc = e_fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        exceptionFlush_i = 1'b0;
        exceptionPC_i    = '0;
        mispredFlush_i   = 1'b0;
        mispredPC_i      = '0;
        decodeStall_i    = 1'b0;
        fs2Ready_i       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Hand-computed sequence: stall, mispredict redirect, priority, re-flush in FLUSH.
        tbl[0]  = mk(0, 0,     0, 0,      0, 0, 0, 0, 32'h0,    2'd0, 8'd0, 8'd0);
        tbl[1]  = mk(0, 0,     0, 0,      1, 0, 1, 0, 32'h0,    2'd0, 8'd0, 8'd0);
        tbl[2]  = mk(0, 0,     0, 0,      1, 0, 1, 0, 32'h0,    2'd1, 8'd1, 8'd0);
        tbl[3]  = mk(0, 0,     0, 0,      0, 0, 0, 0, 32'h0,    2'd1, 8'd2, 8'd0);
        tbl[4]  = mk(0, 0,     0, 0,      0, 0, 0, 0, 32'h0,    2'd0, 8'd2, 8'd0);
        tbl[5]  = mk(0, 0,     1, 'h1000, 1, 0, 1, 0, 32'h0,    2'd0, 8'd2, 8'd0);
        tbl[6]  = mk(0, 0,     0, 0,      0, 0, 0, 1, 32'h1000, 2'd2, 8'd3, 8'd1);
        tbl[7]  = mk(0, 0,     0, 0,      0, 0, 0, 0, 32'h1000, 2'd3, 8'd3, 8'd1);
        tbl[8]  = mk(0, 0,     0, 0,      0, 1, 0, 0, 32'h1000, 2'd3, 8'd3, 8'd1);
        tbl[9]  = mk(0, 0,     0, 0,      0, 0, 0, 0, 32'h1000, 2'd0, 8'd3, 8'd1);
        tbl[10] = mk(1, 'h80,  1, 'h2000, 0, 0, 0, 0, 32'h1000, 2'd0, 8'd3, 8'd1);
        tbl[11] = mk(0, 0,     0, 0,      0, 0, 0, 1, 32'h80,   2'd2, 8'd3, 8'd2);
        tbl[12] = mk(0, 0,     0, 0,      1, 1, 1, 0, 32'h80,   2'd3, 8'd3, 8'd2);
        tbl[13] = mk(0, 0,     0, 0,      0, 0, 0, 0, 32'h80,   2'd1, 8'd4, 8'd2);
        tbl[14] = mk(0, 0,     0, 0,      0, 0, 0, 0, 32'h80,   2'd0, 8'd4, 8'd2);
        tbl[15] = mk(0, 0,     1, 'h3000, 0, 0, 0, 0, 32'h80,   2'd0, 8'd4, 8'd2);
        tbl[16] = mk(0, 0,     1, 'h4000, 0, 0, 0, 1, 32'h3000, 2'd2, 8'd4, 8'd3);
        tbl[17] = mk(0, 0,     0, 0,      0, 0, 0, 1, 32'h4000, 2'd2, 8'd4, 8'd4);
        tbl[18] = mk(0, 0,     0, 0,      0, 1, 0, 0, 32'h4000, 2'd3, 8'd4, 8'd4);
        tbl[19] = mk(0, 0,     0, 0,      0, 0, 0, 0, 32'h4000, 2'd0, 8'd4, 8'd4);

        // Reset held with active inputs: everything reads 0, state RUN.
        idle_inputs();
        reset = 1'b0;
        decodeStall_i = 1'b1;
        exceptionFlush_i = 1'b1;
        @(negedge clk);
        chk("rst_f2dstall", {31'b0, f2dStall_o}, 32'd0);
        chk("rst_fetchstall", {31'b0, fetchStall_o}, 32'd0);
        chk("rst_flush", {31'b0, f2dFlush_o}, 32'd0);
        chk("rst_en", {31'b0, redirectEn_o}, 32'd0);
        chk("rst_pc", redirectPC_o, 32'd0);
        chk("rst_state", {30'b0, ctrlState_o}, 32'd0);
        chk("rst_scnt", {24'b0, stallCount_o}, 32'd0);
        chk("rst_fcnt", {24'b0, flushCount_o}, 32'd0);

        // Ten idle cycles after release stay in RUN with quiet outputs.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_state", {30'b0, ctrlState_o}, 32'd0);
            chk("idle_outs", {28'b0, f2dStall_o, fetchStall_o, f2dFlush_o, redirectEn_o}, 32'd0);
            next_cycle();
        end

        // Vector table.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            exceptionFlush_i = tbl[k].exc;
            exceptionPC_i    = tbl[k].epc;
            mispredFlush_i   = tbl[k].mis;
            mispredPC_i      = tbl[k].mpc;
            decodeStall_i    = tbl[k].ds;
            fs2Ready_i       = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_f2dstall", k), {31'b0, f2dStall_o}, {31'b0, tbl[k].e_stall});
            chk($sformatf("v%0d_fetchstall", k), {31'b0, fetchStall_o}, {31'b0, tbl[k].e_stall});
            chk($sformatf("v%0d_flush", k), {31'b0, f2dFlush_o}, {31'b0, tbl[k].e_flush});
            chk($sformatf("v%0d_en", k), {31'b0, redirectEn_o}, {31'b0, tbl[k].e_flush});
            chk($sformatf("v%0d_pc", k), redirectPC_o, tbl[k].e_pc);
            chk($sformatf("v%0d_state", k), {30'b0, ctrlState_o}, {30'b0, tbl[k].e_st});
            chk($sformatf("v%0d_scnt", k), {24'b0, stallCount_o}, {24'b0, tbl[k].e_sc});
            chk($sformatf("v%0d_fcnt", k), {24'b0, flushCount_o}, {24'b0, tbl[k].e_fc});
            next_cycle();
        end

        // Refill timeout retry, then a new request in the last timeout cycle.
        do_reset();
        mispredFlush_i = 1'b1;
        mispredPC_i    = 32'h5000;
        @(negedge clk);
        chk("tmo_start_state", {30'b0, ctrlState_o}, 32'd0);
        for (int i = 1; i <= 2 * TMO + 1; i++) begin
            next_cycle();
            mispredFlush_i = (i == 2 * TMO);
            mispredPC_i    = 32'h6000;
            @(negedge clk);
            if (i == 1 || i == TMO + 1 || i == 2 * TMO + 1) begin
                chk($sformatf("tmo_c%0d_state", i), {30'b0, ctrlState_o}, 32'd2);
                chk($sformatf("tmo_c%0d_en", i), {31'b0, redirectEn_o}, 32'd1);
                chk($sformatf("tmo_c%0d_pc", i), redirectPC_o,
                    (i == 2 * TMO + 1) ? 32'h6000 : 32'h5000);
                chk($sformatf("tmo_c%0d_fcnt", i), {24'b0, flushCount_o},
                    (i == 1) ? 32'd1 : ((i == TMO + 1) ? 32'd2 : 32'd3));
            end else begin
                chk($sformatf("tmo_c%0d_state", i), {30'b0, ctrlState_o}, 32'd3);
                chk($sformatf("tmo_c%0d_en", i), {31'b0, redirectEn_o}, 32'd0);
            end
        end

        // Reset asserted during the FLUSH cycle drops the redirect immediately.
        do_reset();
        exceptionFlush_i = 1'b1;
        exceptionPC_i    = 32'h700;
        next_cycle();
        exceptionFlush_i = 1'b0;
        @(negedge clk);
        chk("rstmid_en_before", {31'b0, redirectEn_o}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rstmid_flush", {31'b0, f2dFlush_o}, 32'd0);
        chk("rstmid_en", {31'b0, redirectEn_o}, 32'd0);
        chk("rstmid_pc", redirectPC_o, 32'd0);
        chk("rstmid_state", {30'b0, ctrlState_o}, 32'd0);
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_after_state", {30'b0, ctrlState_o}, 32'd0);
            chk("rstmid_after_en", {31'b0, redirectEn_o}, 32'd0);
            next_cycle();
        end

        // Stall counter saturation.
        do_reset();
        decodeStall_i = 1'b1;
        repeat ((1 << CNT_W) + 5) next_cycle();
        decodeStall_i = 1'b0;
        @(negedge clk);
        chk("sat_scnt", {24'b0, stallCount_o}, 32'd255);

        // Flush counter saturation: a request every cycle re-enters FLUSH each edge.
        do_reset();
        mispredFlush_i = 1'b1;
        mispredPC_i    = 32'h44;
        repeat ((1 << CNT_W) + 5) next_cycle();
        @(negedge clk);
        chk("sat_fcnt", {24'b0, flushCount_o}, 32'd255);
        chk("sat_f_state", {30'b0, ctrlState_o}, 32'd2);
        chk("sat_f_pc", redirectPC_o, 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
